// File: rtl/anita3_scaler_reader_if.sv
// rtl/anita3_scaler_reader_if.sv - scaler read bus and record word stream between reader and its neighbours
interface anita3_scaler_reader_if;
    logic [5:0]  scal_addr;
    logic [31:0] scal_dat;
    logic [31:0] rd_dat;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready;

    // The reader drives the scaler address and the outgoing stream.
    modport master (
        output scal_addr,
        input  scal_dat,
        output rd_dat,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    // Scaler block plus downstream packer as seen from the other side.
    modport slave (
        input  scal_addr,
        output scal_dat,
        input  rd_dat,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/anita3_scaler_reader.sv
// rtl/anita3_scaler_reader.sv - per-PPS scaler sweep into a framed record stream; SCALER_READER_CKSUM_EN appends an XOR checksum word
module anita3_scaler_reader #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  HDR_TAG       = 8'hA3
) (
    input  logic                     clk33_i,
    input  logic                     rst_n_i,
    input  logic                     pps_i,
    anita3_scaler_reader_if.master   bus,
    output logic                     busy_o,
    output logic [7:0]               missed_o
);

    localparam logic [4:0] NDATA  = 5'd19;
`ifdef SCALER_READER_CKSUM_EN
    localparam logic [7:0] NWORDS = 8'd20;
`else
    localparam logic [7:0] NWORDS = 8'd19;
`endif

    typedef enum logic [2:0] {IDLE, SETTLE, SEND, FETCH, DONE} state_t;

    state_t      state_q, state_d;
    logic        pps_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  missed_q, missed_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] dat_q, dat_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
`ifdef SCALER_READER_CKSUM_EN
    logic [31:0] acc_q, acc_d;
`endif

    logic        pps_edge;
    logic [31:0] header;

    // Fixed scaler map: L3/L3-mon block, then refpulse, C3PO, {sec, deadtime}.
    function automatic logic [5:0] map_addr(input logic [4:0] idx);
        case (idx)
            5'd16:   map_addr = 6'h20;
            5'd17:   map_addr = 6'h27;
            5'd18:   map_addr = 6'h29;
            default: map_addr = {2'b01, idx[3:0]};
        endcase
    endfunction

    assign pps_edge = pps_i & ~pps_q;
    assign header   = {HDR_TAG, seq_q, missed_q, NWORDS};

    // Record sequencer: next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        missed_d = missed_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
`ifdef SCALER_READER_CKSUM_EN
        acc_d    = acc_q;
`endif
        // Edges arriving outside IDLE (including the DONE cycle) are dropped and counted.
        if (pps_edge && state_q != IDLE && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (pps_edge) begin
                    busy_d  = 1'b1;
                    cnt_d   = 8'(SETTLE_CYCLES);
                    idx_d   = 5'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
`ifdef SCALER_READER_CKSUM_EN
                acc_d = 32'd0;
`endif
                if (cnt_q == 8'd0) begin
                    dat_d   = header;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
`ifdef SCALER_READER_CKSUM_EN
                    acc_d   = header;
`endif
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SEND: begin
                if (bus.rd_ready) begin
                    if (idx_q < NDATA) begin
                        addr_d  = map_addr(idx_q);
                        valid_d = 1'b0;
                        state_d = FETCH;
`ifdef SCALER_READER_CKSUM_EN
                    end else if (idx_q == NDATA) begin
                        // Checksum word follows the 0x29 word back to back.
                        dat_d = acc_q;
                        last_d = 1'b1;
                        idx_d = NDATA + 5'd1;
`endif
                    end else begin
                        // Drop valid at the final handshake so DONE never re-offers the word.
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                dat_d   = bus.scal_dat;
                valid_d = 1'b1;
                idx_d   = idx_q + 5'd1;
`ifdef SCALER_READER_CKSUM_EN
                last_d  = 1'b0;
                acc_d   = acc_q ^ bus.scal_dat;
`else
                last_d  = (idx_q == NDATA - 5'd1);
`endif
                state_d = SEND;
            end
            DONE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                seq_d   = seq_q + 8'd1;
                addr_d  = 6'h00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any record in flight.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            pps_q    <= 1'b0;
            cnt_q    <= 8'd0;
            idx_q    <= 5'd0;
            seq_q    <= 8'd0;
            missed_q <= 8'd0;
            addr_q   <= 6'h00;
            dat_q    <= 32'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SCALER_READER_CKSUM_EN
            acc_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            pps_q    <= pps_i;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            missed_q <= missed_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
`ifdef SCALER_READER_CKSUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign bus.scal_addr = addr_q;
    assign bus.rd_dat    = dat_q;
    assign bus.rd_valid  = valid_q;
    assign bus.rd_last   = last_q;
    assign busy_o        = busy_q;
    assign missed_o      = missed_q;

endmodule
